// File: rtl/zeroriscy_dbus_pkg.sv
// Shared command/response types for the zero-riscy data-port master.
package zeroriscy_dbus_pkg;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dbus_cmd_t;

    typedef struct packed {
        logic        we;
        logic [31:0] rdata;
        logic        err;
    } dbus_rsp_t;

    localparam logic [3:0] BE_READ = 4'hF;

endpackage

// File: rtl/zeroriscy_d_tag_fifo.sv
// Small FIFO of write-enable tags, one per granted-but-unanswered transaction.
// Push and pop in the same cycle are both applied.
module zeroriscy_d_tag_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_we,
    input  logic pop,
    output logic head_we,
    output logic full,
    output logic empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] mem_reg;
    logic [DEPTH-1:0] wr_sel;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
        assign wr_sel[gi] = push & (wr_ptr_reg == PW'(gi));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            mem_reg <= (mem_reg & ~wr_sel) | (wr_sel & {DEPTH{push_we}});
            if (push)
                wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    assign head_we = mem_reg[rd_ptr_reg];
    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);

endmodule

// File: rtl/zeroriscy_d_master.sv
// Initiator for the zero-riscy req/gnt/rvalid data port; in-order, one response per command.
// Optional response timeout enabled by defining ZERORISCY_D_MASTER_TIMEOUT_EN.
module zeroriscy_d_master
    import zeroriscy_dbus_pkg::*;
#(
    parameter int MAX_OUTST   = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_be,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_we,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        p_req,
    output logic        p_we,
    output logic [3:0]  p_be,
    output logic [31:0] p_addr,
    output logic [31:0] p_wdata,
    input  logic        p_gnt,
    input  logic        p_rvalid,
    input  logic [31:0] p_rdata,
    input  logic        p_err,
    output logic        busy,
    output logic        proto_err
);

    localparam int CW = $clog2(MAX_OUTST) + 1;

    dbus_cmd_t     req_reg;
    logic          p_req_reg;
    logic [CW-1:0] outst_reg;
    logic [CW-1:0] outst_next;
    dbus_rsp_t     rsp_reg;
    logic          rsp_valid_reg;
    logic          proto_err_reg;

    logic grant;
    logic rvalid_ok;
    logic timeout_pop;
    logic pop;
    logic tag_head;
    logic fifo_full;
    logic fifo_empty;

    assign grant      = p_req_reg & p_gnt;
    assign rvalid_ok  = p_rvalid & ~fifo_empty;
    assign pop        = rvalid_ok | timeout_pop;
    assign outst_next = outst_reg + CW'(grant) - CW'(pop);

    // Gate on next cycle's occupancy so a command accepted now can always be granted later.
    assign cmd_ready = (~p_req_reg | p_gnt)
                     & (outst_next < CW'(MAX_OUTST))
                     & ~(fifo_full & ~pop);

`ifdef ZERORISCY_D_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt_reg;

    assign timeout_pop = (outst_reg != '0) & ~p_rvalid & (to_cnt_reg == TW'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (!rst_n || p_rvalid || outst_reg == '0 || timeout_pop)
            to_cnt_reg <= '0;
        else
            to_cnt_reg <= to_cnt_reg + 1'b1;
    end
`else
    assign timeout_pop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_req_reg <= 1'b0;
            req_reg   <= '0;
        end else if (cmd_valid && cmd_ready) begin
            p_req_reg <= 1'b1;
            req_reg   <= '{we: cmd_we, be: cmd_we ? cmd_be : BE_READ,
                           addr: cmd_addr, wdata: cmd_wdata};
        end else if (grant) begin
            p_req_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outst_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_reg       <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            outst_reg     <= outst_next;
            rsp_valid_reg <= pop;
            if (timeout_pop)
                rsp_reg <= '{we: tag_head, rdata: 32'h0, err: 1'b1};
            else if (rvalid_ok)
                rsp_reg <= '{we: tag_head, rdata: tag_head ? 32'h0 : p_rdata, err: p_err};
            else
                rsp_reg <= '0;
            if (p_rvalid && outst_reg == '0)
                proto_err_reg <= 1'b1;
        end
    end

    zeroriscy_d_tag_fifo #(
        .DEPTH(MAX_OUTST)
    ) u_tag_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (grant),
        .push_we(req_reg.we),
        .pop    (pop),
        .head_we(tag_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign p_req     = p_req_reg;
    assign p_we      = req_reg.we;
    assign p_be      = req_reg.be;
    assign p_addr    = req_reg.addr;
    assign p_wdata   = req_reg.wdata;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_we    = rsp_reg.we;
    assign rsp_rdata = rsp_reg.rdata;
    assign rsp_err   = rsp_reg.err;
    assign busy      = p_req_reg | (outst_reg != '0);
    assign proto_err = proto_err_reg;

endmodule
